// File: rtl/reg_bank_rtc_sequencer.sv
// Register-bank to RTC write sequencer: strobes each bank entry from the input mux,
// then hands its index to the RTC bus over req/ack with a per-transfer timeout.
module reg_bank_rtc_sequencer #(
  parameter int N_REGS  = 9,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  output logic [SEL_W-1:0] Selector,
  output logic             Reg_WE,
  output logic             RTC_Req,
  output logic [7:0]       RTC_Addr,
  input  logic             RTC_Ack,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_REQ, S_DONE, S_ABORT
  } state_t;

  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_REGS - 1);
  localparam logic [7:0]       TO_M1 = 8'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             w_start_acc, w_active;

  function automatic logic [7:0] f_map(input logic [SEL_W-1:0] idx);
    case (int'(idx))
      0:       f_map = 8'h21;
      1:       f_map = 8'h22;
      2:       f_map = 8'h23;
      3:       f_map = 8'h24;
      4:       f_map = 8'h25;
      5:       f_map = 8'h26;
      6:       f_map = 8'h41;
      7:       f_map = 8'h42;
      8:       f_map = 8'h43;
      default: f_map = 8'h00;
    endcase
  endfunction

  assign w_start_acc = (r_state == S_IDLE) && Start;
  assign w_active    = (w_state_nxt == S_LOAD) || (w_state_nxt == S_SETTLE) ||
                       (w_state_nxt == S_REQ);

  // REQ lasts at most TIMEOUT cycles; an ack on the last of them still wins.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: if (Start) begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
      S_LOAD:   w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (RTC_Ack) begin
          w_cnt_nxt = '0;
          if (r_idx == LAST) w_state_nxt = S_DONE;
          else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_LOAD;
          end
        end else if (r_cnt == TO_M1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_ABORT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE, S_ABORT: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      Selector <= '0;
      Reg_WE   <= 1'b0;
      RTC_Req  <= 1'b0;
      RTC_Addr <= 8'h00;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      Selector <= w_active ? w_idx_nxt : '0;
      Reg_WE   <= (w_state_nxt == S_LOAD);
      RTC_Req  <= (w_state_nxt == S_REQ);
      Busy     <= w_active;
      Done     <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_SETTLE) RTC_Addr <= f_map(w_idx_nxt);
      if (w_start_acc)                    Error <= 1'b0;
      else if (w_state_nxt == S_ABORT)    Error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bank_rtc_sequencer.sv
// Scoreboard bench: stimulus queues expected bank-write / request / done / error events,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_reg_bank_rtc_sequencer;

  localparam int N    = 9;
  localparam int TO   = 255;
  localparam int EV_WE = 0, EV_REQ = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct { int kind; int val; } ev_t;

  logic       clk = 1'b0;
  logic       reset, Start, RTC_Ack;
  logic [3:0] Selector;
  logic [7:0] RTC_Addr;
  logic       Reg_WE, RTC_Req, Busy, Done, Error;

  int   checks = 0, errors = 0;
  int   cyc = 0, start_cyc = 0, done_cyc = 0;
  ev_t  sb[$];
  int   amap[N] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43};

  reg_bank_rtc_sequencer #(.N_REGS(N), .SEL_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Selector(Selector), .Reg_WE(Reg_WE),
    .RTC_Req(RTC_Req), .RTC_Addr(RTC_Addr), .RTC_Ack(RTC_Ack), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input int k, input int v);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=%0d/%0h required=none", k, v);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL event actual=%0d/%0h required=%0d/%0h", k, v, e.kind, e.val);
      end
    end
  endtask

  // Monitor
  initial begin
    bit req_q = 1'b0, err_q = 1'b0;
    int last_sel = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (Reg_WE) begin chk_ev(EV_WE, int'(Selector)); last_sel = int'(Selector); end
        if (RTC_Req && !req_q) chk_ev(EV_REQ, int'(RTC_Addr));
        if (RTC_Req) chk("sel_hold", int'(Selector), last_sel);
        if (Done) begin chk_ev(EV_DONE, 0); done_cyc = cyc; end
        if (Error && !err_q) chk_ev(EV_ERR, 0);
      end
      req_q = RTC_Req;
      err_q = Error;
    end
  end

  task automatic push_seq();
    for (int i = 0; i < N; i++) begin
      sb.push_back('{kind: EV_WE, val: i});
      sb.push_back('{kind: EV_REQ, val: amap[i]});
    end
    sb.push_back('{kind: EV_DONE, val: 0});
  endtask

  task automatic wait_sig(input bit want_req, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ((want_req ? RTC_Req : Reg_WE) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_sel"},  int'(Selector), 0);
    chk({nm, "_we"},   int'(Reg_WE), 0);
    chk({nm, "_req"},  int'(RTC_Req), 0);
    chk({nm, "_addr"}, int'(RTC_Addr), 0);
    chk({nm, "_busy"}, int'(Busy), 0);
    chk({nm, "_done"}, int'(Done), 0);
    chk({nm, "_err"},  int'(Error), 0);
  endtask

  // dly: extra REQ cycles before ack (0 = ack on first REQ cycle)
  task automatic run_seq(input int dly, input int dly_last, input int restart_at,
                         input int reset_at, input bit spur);
    int  d, w, exp_cyc;
    bit  ok;
    push_seq();
    exp_cyc = 1;
    Start = 1'b1; start_cyc = cyc;
    @(negedge clk); Start = 1'b0;
    chk("busy_on", int'(Busy), 1);
    chk("err_clr", int'(Error), 0);
    for (int i = 0; i < N; i++) begin
      d = (i == N - 1) ? dly_last : dly;
      exp_cyc += 3 + d;
      if (spur) begin
        wait_sig(1'b0, ok);
        chk("spur_we_seen", int'(ok), 1);
        RTC_Ack = 1'b1;
      end
      wait_sig(1'b1, ok);
      chk("req_seen", int'(ok), 1);
      RTC_Ack = 1'b0;
      if (!ok) begin sb.delete(); return; end
      if (i == reset_at) begin
        #2 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        chk("sb_left", sb.size(), 2 * (N - 1 - i) + 1);
        sb.delete();
        @(negedge clk); reset = 1'b1;
        return;
      end
      w = 0;
      if (i == restart_at) begin
        Start = 1'b1; @(negedge clk); Start = 1'b0; w = 1;
      end
      repeat (d - w) @(negedge clk);
      RTC_Ack = 1'b1;
      @(posedge clk); #1 RTC_Ack = 1'b0;
    end
    @(negedge clk); #2;
    chk("done_pulse", int'(Done), 1);
    chk("busy_off", int'(Busy), 0);
    chk("done_cycle", done_cyc - start_cyc, exp_cyc);
    @(negedge clk); #2;
    chk("done_once", int'(Done), 0);
    chk("err_none", int'(Error), 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit ok;
    reset = 1'b0; Start = 1'b1; RTC_Ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    Start = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_start_ignored", int'(Busy), 0);

    // full walk, ack one cycle after each request rise
    run_seq(1, 1, -1, -1, 1'b0);
    // ack on first REQ cycle: Done at cycle 28
    run_seq(0, 0, -1, -1, 1'b0);

    // timeout at index 0
    sb.push_back('{kind: EV_WE, val: 0});
    sb.push_back('{kind: EV_REQ, val: 'h21});
    sb.push_back('{kind: EV_ERR, val: 0});
    Start = 1'b1; @(negedge clk); Start = 1'b0;
    wait_sig(1'b1, ok);
    chk("to_req_seen", int'(ok), 1);
    repeat (TO - 1) @(negedge clk);
    chk("to_last_req", int'(RTC_Req), 1);
    chk("to_last_err", int'(Error), 0);
    @(negedge clk); #2;
    chk("to_err", int'(Error), 1);
    chk("to_req_drop", int'(RTC_Req), 0);
    chk("to_busy", int'(Busy), 0);
    chk("to_sel", int'(Selector), 0);
    chk("to_no_done", int'(Done), 0);
    @(negedge clk); #2;
    chk("to_err_sticky", int'(Error), 1);
    chk("to_sb_empty", sb.size(), 0);
    run_seq(0, 0, -1, -1, 1'b0);

    // Start while busy at index 4
    run_seq(1, 1, 4, -1, 1'b0);

    // spurious acks in IDLE, then in LOAD/SETTLE
    RTC_Ack = 1'b1;
    repeat (3) @(negedge clk);
    RTC_Ack = 1'b0;
    chk("idle_ack_busy", int'(Busy), 0);
    chk("idle_ack_sel", int'(Selector), 0);
    run_seq(1, 1, -1, -1, 1'b1);

    // reset during REQ at index 5
    run_seq(1, 1, -1, 5, 1'b0);
    repeat (10) @(negedge clk);
    chk("post_rst_busy", int'(Busy), 0);
    chk("post_rst_we", int'(Reg_WE), 0);
    chk("post_rst_err", int'(Error), 0);
    run_seq(0, 0, -1, -1, 1'b0);

    // ack on the very last allowed REQ cycle at index 8
    run_seq(0, TO - 1, -1, -1, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
